// File: rtl/ftdi_sync_fifo_device_model.sv
// Device-side model of an FT245-style synchronous FIFO chip: RX (host->FPGA) and TX (FPGA->host) byte buffers behind AXIS.
// Latency: status flags registered from next-state levels; bus data is combinational from the registered RX head.
// Backpressure: s_axis_tready drops when RX is full; m_axis honours tready; ftdi_txe_n high blocks FPGA writes.
// Optional build macro FTDI_MODEL_THROTTLE_EN adds LFSR-driven random flag throttling.

// Generic synchronous FIFO; pointers carry an extra MSB, full/empty is decided from the level.
// Latency: a pushed word is visible at head one cycle after the push edge.
// Backpressure: the caller gates push/pop; this block never refuses or checks them.
module ftdi_model_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  // Next-state occupancy; push and pop together leave it unchanged.
  always_comb begin
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + LW'(1);
      2'b01:   level_next = level_q - LW'(1);
      default: level_next = level_q;
    endcase
  end

  // Pointer and level registers; reset flushes the buffer by clearing them.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
      level_q <= level_next;
    end
  end

  // Storage array; contents need no reset because the level defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = level_q;
endmodule

// FTDI device emulator top: plays the chip side of the synchronous FIFO bus.
// Latency: RX byte reaches the bus one cycle after its s_axis push; a captured TX byte appears on m_axis next cycle.
// Backpressure: rxf_n/txe_n reflect buffer occupancy (optionally throttled); AXIS sides use valid/ready.
module ftdi_sync_fifo_device_model #(
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       res_n,
  output logic                       ftdi_rxf_n,
  output logic                       ftdi_txe_n,
  input  logic                       ftdi_rd_n,
  input  logic                       ftdi_oe_n,
  input  logic                       ftdi_wr_n,
  inout  wire  [7:0]                 ftdi_data,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic [$clog2(TX_DEPTH):0]  tx_level,
  output logic                       protocol_error
);
  localparam int RLW = $clog2(RX_DEPTH) + 1;
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam logic [RLW-1:0] RX_FULL = RLW'(RX_DEPTH);
  localparam logic [TLW-1:0] TX_FULL = TLW'(TX_DEPTH);

  logic           rx_push;
  logic           rx_pop;
  logic [7:0]     rx_head;
  logic [RLW-1:0] rx_level_next;
  logic           tx_push;
  logic           tx_pop;
  logic [TLW-1:0] tx_level_next;
  logic           bus_drive;
  logic [7:0]     bus_value;
  logic           contention;
  logic           read_without_oe;
  logic           throttle;

  // Host->FPGA buffer: filled from s_axis, drained by FPGA read strobes.
  ftdi_model_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) rx_fifo (
    .clk        (clk),
    .res_n      (res_n),
    .push       (rx_push),
    .push_data  (s_axis_tdata),
    .pop        (rx_pop),
    .head       (rx_head),
    .level      (rx_level),
    .level_next (rx_level_next)
  );

  // FPGA->host buffer: filled by FPGA write strobes, drained to m_axis.
  ftdi_model_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) tx_fifo (
    .clk        (clk),
    .res_n      (res_n),
    .push       (tx_push),
    .push_data  (ftdi_data),
    .pop        (tx_pop),
    .head       (m_axis_tdata),
    .level      (tx_level),
    .level_next (tx_level_next)
  );

  // Ready depends on level alone, so a full buffer refuses a push even if a pop is happening.
  assign s_axis_tready = (rx_level != RX_FULL);
  assign rx_push       = s_axis_tvalid & s_axis_tready;
  // The registered flag gates the pop, so the byte taken is the one shown on the bus this cycle.
  assign rx_pop        = ~ftdi_rd_n & ~ftdi_rxf_n;

  assign tx_push       = ~ftdi_wr_n & ~ftdi_txe_n;
  // Held low during reset so an in-flight byte is never emitted.
  assign m_axis_tvalid = res_n & (tx_level != '0);
  assign tx_pop        = m_axis_tvalid & m_axis_tready;

  // Bus drive: RX head (or zero when empty) whenever the FPGA asks via OE, released in reset.
  assign bus_drive = res_n & ~ftdi_oe_n;
  assign bus_value = (rx_level != '0) ? rx_head : 8'h00;
  assign ftdi_data = bus_drive ? bus_value : 8'hzz;

  assign contention      = ~ftdi_oe_n & ~ftdi_wr_n;
  assign read_without_oe = ~ftdi_rd_n &  ftdi_oe_n;

`ifdef FTDI_MODEL_THROTTLE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign throttle = lfsr[0];

  // Throttle LFSR advances every cycle out of reset.
  always_ff @(posedge clk) begin
    if (!res_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  // No throttling; the seed only matters when the LFSR exists.
  assign throttle = 1'b0 & (LFSR_SEED == 16'h0000);
`endif

  // Status flags from next-state levels, plus the sticky protocol violation flag.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      ftdi_rxf_n     <= 1'b1;
      ftdi_txe_n     <= 1'b1;
      protocol_error <= 1'b0;
    end else begin
      ftdi_rxf_n <= (rx_level_next == '0) | throttle;
      ftdi_txe_n <= (tx_level_next == TX_FULL) | throttle;
      if (contention | read_without_oe) protocol_error <= 1'b1;
    end
  end
endmodule

// File: doc/ftdi_sync_fifo_device_model.md
Name: ftdi_sync_fifo_device_model

Overview:
- Synthesizable device-side emulator of the FT245-style synchronous FIFO interface. It plays the FTDI chip, driving rxf_n/txe_n and the data bus, and responds to rd_n/oe_n/wr_n from the FPGA-side FTDI master.
- Host traffic is presented as AXIS streams: s_axis bytes are queued for the FPGA to read, and bytes the FPGA writes appear on m_axis.
- Used in loopback benches and FPGA self-test builds to exercise the FTDI master without a physical chip.

Parameters:
- RX_DEPTH, 16, depth of host->FPGA buffer (power of 2, >=4).
- TX_DEPTH, 16, depth of FPGA->host buffer (power of 2, >=4).
- LFSR_SEED, 16'hACE1, seed for throttle LFSR (optional feature only; nonzero).

Ports:
- clk  in  1  interface clock (plays ftdi_clko).
- res_n  in  1  synchronous active-low reset.
- ftdi_rxf_n  out  1  low = RX buffer holds data for FPGA.
- ftdi_txe_n  out  1  low = TX buffer can accept a byte.
- ftdi_rd_n  in  1  FPGA read strobe.
- ftdi_oe_n  in  1  FPGA output-enable request; low = model drives bus.
- ftdi_wr_n  in  1  FPGA write strobe.
- ftdi_data  inout  8  shared data bus.
- s_axis_tdata  in  8  host byte to send to FPGA.
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready.
- m_axis_tdata  out  8  byte written by FPGA.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy.
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy.
- protocol_error  out  1  sticky protocol violation flag.

Behaviour:
- Reset (res_n=0 at posedge): both buffers flushed, pointers/levels=0, ftdi_rxf_n=1, ftdi_txe_n=1, protocol_error=0, throttle LFSR=LFSR_SEED. ftdi_data released (Z) whenever res_n=0 or ftdi_oe_n=1.
- Bus drive: ftdi_data = RX head byte when ftdi_oe_n=0 and RX non-empty; drives 8'h00 when ftdi_oe_n=0 and RX empty. Combinational from registered head, no pipeline.
- RX push: s_axis_tready = (rx_level != RX_DEPTH), combinational. Push on s_axis_tvalid & s_axis_tready.
- RX pop: at posedge with ftdi_rd_n=0 & ftdi_rxf_n=0 (registered value). Byte popped = byte on bus that cycle.
- TX push: at posedge with ftdi_wr_n=0 & ftdi_txe_n=0, capture ftdi_data. Writes while txe_n=1 are ignored.
- TX pop: m_axis_tvalid = (tx_level != 0); m_axis_tdata = TX head; pop on tvalid & tready.
- Flags are registered from next-state levels, so status is never stale:
  - ftdi_rxf_n <= (rx_level_next == 0)
  - ftdi_txe_n <= (tx_level_next == TX_DEPTH)
- First posedge after reset release sets txe_n=0. rxf_n falls one cycle after the first push and rises at the same edge as the last pop.
- Simultaneous push+pop on the same buffer: level unchanged, FIFO order preserved. RX full plus simultaneous pop still blocks push, because tready depends on level only.
- Pointer wrap: modulo depth with extra MSB; full/empty decided by level.
- protocol_error set (sticky until reset) at posedge when:
  - ftdi_oe_n=0 & ftdi_wr_n=0 (bus contention), or
  - ftdi_rd_n=0 & ftdi_oe_n=1 (read without OE).
- Flag state otherwise unaffected by errors.
- Reset mid-burst: any in-flight byte is discarded, nothing is emitted on m_axis, and the bus is released in the reset cycle.

Optional Feature:
- Macro FTDI_MODEL_THROTTLE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. When bit0=1, ftdi_rxf_n and ftdi_txe_n are forced to 1 for that registered cycle, regardless of level. This stress-tests master backpressure. Pops/pushes are only accepted when the forced flag value is low.
- Undefined: no LFSR, flags purely level-derived.

Test Plan:
- Reset: res_n=0 for 2 cycles with oe_n=0 -> rxf_n=1, txe_n=1, ftdi_data=Z, m_axis_tvalid=0. One cycle after release, txe_n=0 and rxf_n stays 1.
- Read path: push 8'hA5, 8'h5A via s_axis. rxf_n=0 one cycle after first push. Then oe_n=0, then rd_n=0 for 2 cycles -> bus shows A5 then 5A at those edges, rx_level 2->1->0, rxf_n=1 at the second pop edge.
- Write path: wr_n=0 for 17 cycles with data 0x00..0x10, m_axis_tready=0 -> txe_n=1 after the 16th capture, 0x10 dropped. Draining m_axis yields 0x00..0x0F, and txe_n returns to 0 after the first drain.
- Concurrency/wrap: RX_DEPTH=16, stream 40 bytes 0..39 with push and rd_n pop overlapping every cycle -> FPGA sees 0..39 in order, and rx_level never exceeds 16.
- Protocol error: oe_n=0 & wr_n=0 for one cycle -> protocol_error=1, held through 100 idle cycles, cleared only by res_n=0.
- Throttle (FTDI_MODEL_THROTTLE_EN, seed 16'hACE1): 256-byte loopback -> data intact and in order, and both rxf_n and txe_n observed high while buffers are non-empty/non-full.
